// File: rtl/and_test.sv
// Bitwise AND / AND-NOT unit with optional sticky AND accumulator (AND_TEST_ACCUM_EN).
// Latency: one cycle from accepted input to registered result and out_valid.
// Backpressure: none; every in_valid cycle outside reset is accepted.
module and_test #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             out_valid,
  output logic             zero,
  output logic             all_ones
);

  typedef enum logic [1:0] {
    OP_AND      = 2'b00,
    OP_AND_NOT  = 2'b01,
    OP_ACC      = 2'b10,
    OP_ACC_LOAD = 2'b11
  } op_e;

  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] and_ab;

  assign and_ab = a & b;

`ifdef AND_TEST_ACCUM_EN
  logic [WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    result_d    = result_q;
    out_valid_d = 1'b0;
    acc_d       = acc_q;
    if (in_valid) begin
      out_valid_d = 1'b1;
      case (op_e'(op))
        OP_AND:      result_d = and_ab;
        OP_AND_NOT:  result_d = a & ~b;
        OP_ACC: begin
          acc_d    = acc_q & and_ab;
          result_d = acc_q & and_ab;
        end
        OP_ACC_LOAD: begin
          acc_d    = and_ab;
          result_d = and_ab;
        end
        default:     result_d = and_ab;
      endcase
    end
  end

  // acc resets to all ones so a first ACC after reset passes a & b straight through
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '1;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  always_comb begin
    result_d    = result_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = 1'b1;
      if (op_e'(op) == OP_AND_NOT) begin
        result_d = a & ~b;
      end else begin
        result_d = and_ab;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign zero      = (result_q == '0);
  assign all_ones  = (result_q == '1);

endmodule

// File: tb/tb_and_test.sv
// Directed bench for and_test: behavioural model checked every cycle plus literal expectations.
module tb_and_test;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] result;
  logic       out_valid;
  logic       zero;
  logic       all_ones;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  logic [3:0] m_result;
  logic       m_valid;
  logic [3:0] m_acc;

  and_test #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (result),
    .out_valid(out_valid),
    .zero     (zero),
    .all_ones (all_ones)
  );

  always #5 clk = ~clk;

  // Model: what the outputs must be after an edge, straight from the operation rules.
  task automatic model_edge(input logic r, input logic v, input logic [1:0] o,
                            input logic [3:0] x, input logic [3:0] y);
    if (!r) begin
      m_result = 4'h0;
      m_valid  = 1'b0;
      m_acc    = 4'hF;
    end else if (!v) begin
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b1;
`ifdef AND_TEST_ACCUM_EN
      if (o == 2'd0)      m_result = x & y;
      else if (o == 2'd1) m_result = x & ~y;
      else if (o == 2'd2) begin m_acc = m_acc & x & y; m_result = m_acc; end
      else                begin m_acc = x & y;         m_result = m_acc; end
`else
      m_result = (o == 2'd1) ? (x & ~y) : (x & y);
`endif
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] o,
                      input logic [3:0] x, input logic [3:0] y);
    rst_n    = r;
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
    @(posedge clk);
    model_edge(r, v, o, x, y);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (result !== m_result || out_valid !== m_valid ||
          zero !== (m_result == 4'h0) || all_ones !== (m_result == 4'hF)) begin
        fails++;
        $display("FAIL model t=%0t: result=%h ov=%b z=%b ao=%b, expected result=%h ov=%b z=%b ao=%b",
                 $time, result, out_valid, zero, all_ones, m_result, m_valid,
                 (m_result == 4'h0), (m_result == 4'hF));
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'd0; a = 4'h0; b = 4'h0;
    @(negedge clk);

    // Reset held two edges with in_valid high
    step(1'b0, 1'b1, 2'd0, 4'hF, 4'hF);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 2'd0, 4'hF, 4'hF);
    chk("rst_result", result, 4'h0);
    chk("rst_ov", {3'b0, out_valid}, 4'h0);
    chk("rst_zero", {3'b0, zero}, 4'h1);
    chk("rst_all_ones", {3'b0, all_ones}, 4'h0);

    // Single AND then idle
    step(1'b1, 1'b1, 2'd0, 4'h1, 4'h5);
    chk("and1_result", result, 4'h1);
    chk("and1_ov", {3'b0, out_valid}, 4'h1);
    chk("and1_zero", {3'b0, zero}, 4'h0);
    step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    chk("idle_ov", {3'b0, out_valid}, 4'h0);
    chk("idle_hold", result, 4'h1);

    step(1'b1, 1'b1, 2'd0, 4'hF, 4'hD);
    chk("and_fd", result, 4'hD);
    step(1'b1, 1'b1, 2'd0, 4'hF, 4'hF);
    chk("and_ff_all_ones", {3'b0, all_ones}, 4'h1);
    step(1'b1, 1'b1, 2'd0, 4'hA, 4'h5);
    chk("and_a5_zero", {3'b0, zero}, 4'h1);

    step(1'b1, 1'b1, 2'd1, 4'hF, 4'hD);
    chk("andnot_fd", result, 4'h2);
    step(1'b1, 1'b1, 2'd1, 4'h6, 4'h3);
    chk("andnot_63", result, 4'h4);

    // Accumulator sequence from a fresh reset
    step(1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
    step(1'b1, 1'b1, 2'd2, 4'hE, 4'hF);
    chk("acc1", result, 4'hE);
    step(1'b1, 1'b1, 2'd2, 4'h7, 4'hF);
`ifdef AND_TEST_ACCUM_EN
    chk("acc2", result, 4'h6);
`else
    chk("acc2", result, 4'h7);
`endif
    step(1'b1, 1'b1, 2'd3, 4'hF, 4'h9);
    chk("acc_load", result, 4'h9);
    step(1'b1, 1'b1, 2'd0, 4'h0, 4'h0);
    chk("acc_and00", result, 4'h0);
    step(1'b1, 1'b0, 2'd2, 4'h0, 4'h0);
    step(1'b1, 1'b1, 2'd2, 4'hF, 4'hF);
`ifdef AND_TEST_ACCUM_EN
    chk("acc_kept", result, 4'h9);
`else
    chk("acc_kept", result, 4'hF);
`endif

    // Reset mid-stream cancels pending out_valid
    step(1'b1, 1'b1, 2'd0, 4'hF, 4'hF);
    chk("mid_pre", result, 4'hF);
    step(1'b0, 1'b1, 2'd0, 4'hF, 4'hF);
    chk("mid_rst_ov", {3'b0, out_valid}, 4'h0);
    chk("mid_rst_result", result, 4'h0);
    step(1'b1, 1'b1, 2'd0, 4'h3, 4'h1);
    chk("mid_after", result, 4'h1);
    chk("mid_after_ov", {3'b0, out_valid}, 4'h1);

    // rst_n pulsed low between edges has no effect
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    model_edge(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    #1;
    chk("glitch_hold", result, 4'h1);

    step(1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/and_test.md
AND_TEST -- requirements
Module: and_test

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result bit width (legal range 1..64).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  qualifies a, b and op for the current cycle.
REQ-005 Port: op  input  2  operation select: 00 AND, 01 AND-NOT, 10 ACC, 11 ACC_LOAD.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: result  output  WIDTH  registered operation result.
REQ-009 Port: out_valid  output  1  high for exactly one cycle per accepted input.
REQ-010 Port: zero  output  1  high when result is all zeros.
REQ-011 Port: all_ones  output  1  high when result is all ones.

Function
REQ-012 The block SHALL accept an operation on every rising clk edge where rst_n=1 and in_valid=1; there is no backpressure.
REQ-013 op 00 SHALL register result <= a & b (bitwise).
REQ-014 op 01 SHALL register result <= a & ~b.
REQ-015 op 10 (ACC) SHALL update an internal WIDTH-bit accumulator acc <= acc & a & b and register result <= the new acc value.
REQ-016 op 11 (ACC_LOAD) SHALL set acc <= a & b and register result <= a & b.
REQ-017 Ops 00 and 01 SHALL leave acc unchanged.
REQ-018 Latency SHALL be one cycle: result and out_valid reflect the inputs sampled on the preceding rising edge.
REQ-019 out_valid SHALL be 1 in the cycle after an accepted input and 0 after any edge with in_valid=0.
REQ-020 When in_valid=0, result SHALL hold its previous value and acc SHALL NOT change.
REQ-021 zero and all_ones SHALL be combinational decodes of the result register (no extra latency).
REQ-022 No arithmetic, carry or width extension is involved; all operations are pure bitwise over WIDTH bits.
REQ-023 For WIDTH=1, zero and all_ones SHALL be mutually exclusive and one of them always high.

Reset
REQ-024 On a rising clk edge with rst_n=0: result <= 0, out_valid <= 0, acc <= all ones; therefore zero=1 and all_ones=0.
REQ-025 Reset SHALL take priority over in_valid on the same edge; an input presented during reset is discarded and produces no out_valid.
REQ-026 Reset asserted mid-stream SHALL cancel any pending out_valid; the first accepted input after rst_n returns high produces out_valid one cycle later.
REQ-027 rst_n changes between clock edges SHALL have no effect until the next rising edge.

Configuration
REQ-028 Macro AND_TEST_ACCUM_EN: when defined, the acc register and ops 10/11 SHALL behave per REQ-015/016.
REQ-029 Without AND_TEST_ACCUM_EN, no acc register is built; ops 10 and 11 SHALL behave exactly as op 00 (result <= a & b), and all other behaviour is unchanged.

Verification
REQ-030 Reset: hold rst_n=0 for 2 edges with in_valid=1 -> result=0000, out_valid=0, zero=1, all_ones=0.
REQ-031 AND: op=00, a=0001, b=0101, in_valid=1 for one edge -> next cycle result=0001, out_valid=1, zero=0; following cycle out_valid=0, result held at 0001.
REQ-032 AND: op=00, a=1111, b=1101 -> result=1101; then a=1111, b=1111 -> all_ones=1; then a=1010, b=0101 -> zero=1.
REQ-033 AND-NOT: op=01, a=1111, b=1101 -> result=0010.
REQ-034 Accumulate (macro defined): after reset, op=10 a=1110 b=1111 -> 1110; op=10 a=0111 b=1111 -> 0110; op=11 a=1111 b=1001 -> 1001; op=00 a=0000 b=0000 -> 0000, then op=10 a=1111 b=1111 -> 1001 (acc untouched by op 00). Macro undefined: the op=10 step with a=0111 b=1111 yields 0111.
REQ-035 Reset mid-stream: accept op=00 a=1111 b=1111, assert rst_n=0 on the next edge -> out_valid=0, result=0000; release, accept a=0011 b=0001 -> result=0001 one cycle later.
